// File: rtl/stopwatch_ctrl_if.sv
// Digit and control bundle between stopwatch_ctrl, the Enhanced_Stopwatch datapath and LED_mux.
// The master is the controller; the slave is the datapath/display side.
interface stopwatch_ctrl_if;
    logic [4:0] in0, in1, in2, in3, in4, in5;
    logic [4:0] out0, out1, out2, out3, out4, out5;
    logic       go;
    logic       up;
    logic       clr;

    modport master (
        input  in0, in1, in2, in3, in4, in5,
        output out0, out1, out2, out3, out4, out5,
        output go, up, clr
    );

    modport slave (
        output in0, in1, in2, in3, in4, in5,
        input  out0, out1, out2, out3, out4, out5,
        input  go, up, clr
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Front-panel control for the stopwatch: button debouncing, run/pause/lap FSM,
// lap buffer with recall, and the live/lap select on the digits sent to LED_mux.
module stopwatch_ctrl #(
    parameter int DB_CYCLES   = 1_000_000,
    parameter int HOLD_CYCLES = 150_000_000,
    parameter int LAP_DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       btn_start,
    input  logic                       btn_lap,
    input  logic                       btn_clr,
    input  logic                       sw_up,
    stopwatch_ctrl_if.master           bus,
    output logic [1:0]                 state,
    output logic [$clog2(LAP_DEPTH):0] lap_cnt,
    output logic                       disp_lap
);
    localparam int PW = $clog2(LAP_DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam int TW = $clog2(HOLD_CYCLES + 1);

    localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [LW-1:0] CNT_MAX   = LW'(LAP_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_LAP   = 2'b11;

    // Bit order: 0 start, 1 lap, 2 clr, 3 direction switch.
    logic [3:0]    raw, sync1, sync2, db;
    logic [CW-1:0] db_cnt [4];
    logic [2:0]    rise, ev;

    assign raw = {sw_up, btn_clr, btn_lap, btn_start};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        rise = '0;
        for (int i = 0; i < 3; i++)
            rise[i] = sync2[i] && !db[i] && (db_cnt[i] == DB_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            ev    <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            sync1 <= raw;
            sync2 <= sync1;
            ev    <= rise;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] != db[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        db[i]     <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + CW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Coincident presses resolve clr > start > lap; the losers are dropped.
    logic e_clr, e_start, e_lap, capture;
    logic [PW-1:0] wr_ptr, rd_off, rd_idx;
    logic [TW-1:0] hold_cnt;
    logic          up_q, clr_q;
    logic [29:0]   lap_buf [LAP_DEPTH];
    logic [29:0]   live, out_q;

    always_comb begin
        e_clr   = ev[2];
        e_start = ev[0] && !ev[2];
        e_lap   = ev[1] && !ev[0] && !ev[2];
        capture = e_lap && (state == S_RUN || state == S_LAP);
        rd_idx  = wr_ptr - rd_off - PW'(1);
        live    = {bus.in5, bus.in4, bus.in3, bus.in2, bus.in1, bus.in0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            up_q     <= 1'b0;
            clr_q    <= 1'b0;
            lap_cnt  <= '0;
            disp_lap <= 1'b0;
            wr_ptr   <= '0;
            rd_off   <= '0;
            hold_cnt <= '0;
        end else begin
            clr_q <= 1'b0;
            if (capture) begin
                wr_ptr   <= wr_ptr + PW'(1);
                rd_off   <= '0;
                hold_cnt <= HOLD_LAST;
                if (lap_cnt != CNT_MAX) lap_cnt <= lap_cnt + LW'(1);
            end
            case (state)
                S_IDLE: begin
                    up_q <= db[3];
                    if (e_clr) begin
                        clr_q   <= 1'b1;
                        lap_cnt <= '0;
                    end else if (e_start) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (e_start) begin
                        state <= S_PAUSE;
                    end else if (e_lap) begin
                        state    <= S_LAP;
                        disp_lap <= 1'b1;
                    end
                end
                S_LAP: begin
                    if (e_start) begin
                        state    <= S_PAUSE;
                        disp_lap <= 1'b0;
                    end else if (!e_lap) begin
                        if (hold_cnt == '0) begin
                            state    <= S_RUN;
                            disp_lap <= 1'b0;
                        end else begin
                            hold_cnt <= hold_cnt - TW'(1);
                        end
                    end
                end
                default: begin
                    if (e_clr) begin
                        state    <= S_IDLE;
                        clr_q    <= 1'b1;
                        lap_cnt  <= '0;
                        wr_ptr   <= '0;
                        disp_lap <= 1'b0;
                    end else if (e_start) begin
                        state    <= S_RUN;
                        disp_lap <= 1'b0;
                    end else if (e_lap && lap_cnt != '0) begin
                        // Recall walks back from the newest entry, wrapping over the valid ones.
                        disp_lap <= 1'b1;
                        if (!disp_lap || (LW'(rd_off) + LW'(1) == lap_cnt))
                            rd_off <= '0;
                        else
                            rd_off <= rd_off + PW'(1);
                    end
                end
            endcase
        end
    end

    // NOTE: the lap buffer has no reset; entries are only read once lap_cnt marks them valid.
    always_ff @(posedge clk) begin
        if (capture) lap_buf[wr_ptr] <= live;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_q <= '0;
        else        out_q <= disp_lap ? lap_buf[rd_idx] : live;
    end

    assign bus.go   = state[0];
    assign bus.up   = up_q;
    assign bus.clr  = clr_q;
    assign bus.out0 = out_q[4:0];
    assign bus.out1 = out_q[9:5];
    assign bus.out2 = out_q[14:10];
    assign bus.out3 = out_q[19:15];
    assign bus.out4 = out_q[24:20];
    assign bus.out5 = out_q[29:25];
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with short debounce/hold constants: a vector table for the
// lap capture/recall walk plus hand sequences for glitch, latency, coincident events and reset.
module tb_stopwatch_ctrl;
    localparam int DB   = 4;
    localparam int HOLD = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] btn = 3'b000;
    logic       sw_up = 1'b0;
    logic [1:0] state;
    logic [2:0] lap_cnt;
    logic       disp_lap;

    stopwatch_ctrl_if bus ();

    stopwatch_ctrl #(.DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .LAP_DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_start (btn[0]),
        .btn_lap   (btn[1]),
        .btn_clr   (btn[2]),
        .sw_up     (sw_up),
        .bus       (bus),
        .state     (state),
        .lap_cnt   (lap_cnt),
        .disp_lap  (disp_lap)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int clr_seen;

    typedef struct {
        logic [2:0] mask;
        logic [4:0] din;
        logic [1:0] st;
        logic       go;
        logic       dl;
        logic [2:0] cnt;
        logic [4:0] o0;
        int         nclr;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set6(input int a, input int b, input int c, input int d, input int e, input int f);
        bus.in0 = 5'(a); bus.in1 = 5'(b); bus.in2 = 5'(c);
        bus.in3 = 5'(d); bus.in4 = 5'(e); bus.in5 = 5'(f);
    endtask

    task automatic set_in(input int v);
        set6(v, v, v, v, v, v);
    endtask

    // Holds the buttons for `hold` cycles, then lets the release debounce settle; counts clr pulses.
    task automatic press(input logic [2:0] mask, input int hold);
        clr_seen = 0;
        @(negedge clk);
        btn = mask;
        repeat (hold) begin
            @(negedge clk);
            if (bus.clr) clr_seen++;
        end
        btn = 3'b000;
        repeat (8) begin
            @(negedge clk);
            if (bus.clr) clr_seen++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int n;

        //              mask    din    st     go    dl    cnt   o0     nclr
        tbl[0]  = '{3'b100, 5'd10, 2'd1, 1'b1, 1'b0, 3'd1, 5'd10, 0};
        tbl[1]  = '{3'b010, 5'd1,  2'd3, 1'b1, 1'b1, 3'd2, 5'd1,  0};
        tbl[2]  = '{3'b010, 5'd2,  2'd3, 1'b1, 1'b1, 3'd3, 5'd2,  0};
        tbl[3]  = '{3'b010, 5'd3,  2'd3, 1'b1, 1'b1, 3'd4, 5'd3,  0};
        tbl[4]  = '{3'b010, 5'd4,  2'd3, 1'b1, 1'b1, 3'd4, 5'd4,  0};
        tbl[5]  = '{3'b010, 5'd5,  2'd3, 1'b1, 1'b1, 3'd4, 5'd5,  0};
        tbl[6]  = '{3'b001, 5'd20, 2'd2, 1'b0, 1'b0, 3'd4, 5'd20, 0};
        tbl[7]  = '{3'b010, 5'd20, 2'd2, 1'b0, 1'b1, 3'd4, 5'd5,  0};
        tbl[8]  = '{3'b010, 5'd20, 2'd2, 1'b0, 1'b1, 3'd4, 5'd4,  0};
        tbl[9]  = '{3'b010, 5'd20, 2'd2, 1'b0, 1'b1, 3'd4, 5'd3,  0};
        tbl[10] = '{3'b010, 5'd20, 2'd2, 1'b0, 1'b1, 3'd4, 5'd2,  0};
        tbl[11] = '{3'b010, 5'd20, 2'd2, 1'b0, 1'b1, 3'd4, 5'd5,  0};
        tbl[12] = '{3'b001, 5'd21, 2'd1, 1'b1, 1'b0, 3'd4, 5'd21, 0};

        set_in(7);
        repeat (3) @(negedge clk);
        check("rst_state", state, 0);
        check("rst_go", bus.go, 0);
        check("rst_up", bus.up, 0);
        check("rst_clr", bus.clr, 0);
        check("rst_lap_cnt", lap_cnt, 0);
        check("rst_disp_lap", disp_lap, 0);
        check("rst_out0", bus.out0, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // A 3-cycle glitch never survives the debouncer.
        btn = 3'b001;
        repeat (3) @(negedge clk);
        btn = 3'b000;
        repeat (12) @(negedge clk);
        check("glitch_state", state, 0);
        check("glitch_go", bus.go, 0);

        // Clean press: 2 sync + 4 debounce cycles to the event, FSM one cycle later.
        lat = 0;
        btn = 3'b001;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.go && lat == 0) lat = k;
            if (k == 10) btn = 3'b000;
        end
        check("start_latency", lat, 7);
        check("start_state", state, 1);

        // First lap: display frozen on 1..6 for HOLD cycles while the live digits move.
        set6(1, 2, 3, 4, 5, 6);
        lat = 0;
        btn = 3'b010;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (state == 2'b11) begin
                lat = k;
                break;
            end
        end
        check("lap_entry", lat, 7);
        btn = 3'b000;
        set_in(9);
        n = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (state != 2'b11) break;
            n++;
            if (n == 5) begin
                check("lap_disp", disp_lap, 1);
                check("lap_go", bus.go, 1);
                check("lap_out0", bus.out0, 1);
                check("lap_out2", bus.out2, 3);
                check("lap_out5", bus.out5, 6);
            end
        end
        check("lap_hold_len", n, HOLD);
        check("lap_exit_state", state, 1);
        check("lap_exit_disp", disp_lap, 0);
        @(negedge clk);
        set_in(13);
        #1;
        check("live_before_edge", bus.out0, 9);
        @(posedge clk);
        #1;
        check("live_out0", bus.out0, 13);
        check("live_out5", bus.out5, 13);

        // Table: clr ignored in RUN, five more laps, pause, recall walk, resume.
        for (int i = 0; i < 13; i++) begin
            set_in(int'(tbl[i].din));
            press(tbl[i].mask, 10);
            check($sformatf("row%0d_state", i), state, tbl[i].st);
            check($sformatf("row%0d_go", i), bus.go, tbl[i].go);
            check($sformatf("row%0d_disp_lap", i), disp_lap, tbl[i].dl);
            check($sformatf("row%0d_lap_cnt", i), lap_cnt, tbl[i].cnt);
            check($sformatf("row%0d_out0", i), bus.out0, tbl[i].o0);
            check($sformatf("row%0d_clr", i), clr_seen, tbl[i].nclr);
        end

        // Start, lap and clr together in PAUSE: clr wins, exactly one pulse.
        press(3'b001, 10);
        check("pause_state", state, 2);
        press(3'b111, 10);
        check("coinc_clr_pulses", clr_seen, 1);
        check("coinc_state", state, 0);
        check("coinc_lap_cnt", lap_cnt, 0);
        check("coinc_go", bus.go, 0);
        check("coinc_disp_lap", disp_lap, 0);

        // Direction switch: tracked in IDLE, frozen elsewhere.
        lat = 0;
        sw_up = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.up && lat == 0) lat = k;
        end
        check("up_follow_in_bound", (lat > 0 && lat <= DB + 3) ? 1 : 0, 1);
        press(3'b001, 10);
        check("up_run_state", state, 1);
        sw_up = 1'b0;
        repeat (15) @(negedge clk);
        check("up_frozen_run", bus.up, 1);
        press(3'b001, 10);
        press(3'b100, 10);
        check("up_clear_pulses", clr_seen, 1);
        check("up_clear_state", state, 0);
        repeat (DB + 3) @(negedge clk);
        check("up_follow_idle", bus.up, 0);

        // Asynchronous reset in the middle of LAP.
        press(3'b001, 10);
        set_in(17);
        lat = 0;
        btn = 3'b010;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (state == 2'b11) begin
                lat = k;
                break;
            end
        end
        btn = 3'b000;
        check("rst_lap_reached", lat, 7);
        check("rst_pre_lap_cnt", lap_cnt, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_state", state, 0);
        check("arst_go", bus.go, 0);
        check("arst_disp_lap", disp_lap, 0);
        check("arst_lap_cnt", lap_cnt, 0);
        check("arst_out0", bus.out0, 0);
        check("arst_clr", bus.clr, 0);
        clr_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.clr) clr_seen++;
        end
        check("arst_no_clr", clr_seen, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        press(3'b001, 10);
        check("post_rst_state", state, 1);
        check("post_rst_go", bus.go, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control and sequencing block between the front-panel buttons and the Enhanced_Stopwatch / LED_mux pair.
- Debounces raw buttons, runs the stopwatch run/pause/lap FSM, and drives go/up/clr into the stopwatch datapath.
- Keeps a small lap-time buffer and selects whether the six digit buses reaching LED_mux carry the live count or a frozen/recalled lap.

Parameters:
- DB_CYCLES, 1_000_000, consecutive stable cycles needed before a debounced level change (20 ms at 50 MHz).
- HOLD_CYCLES, 150_000_000, lap freeze-display duration in LAP state (3 s at 50 MHz).
- LAP_DEPTH, 4, lap buffer entries; power of two, ≥2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_start  in  1  raw start/stop button, active-high, asynchronous
- btn_lap  in  1  raw lap/recall button, active-high, asynchronous
- btn_clr  in  1  raw clear button, active-high, asynchronous
- sw_up  in  1  raw direction switch (1 = count up)
- in0..in5  in  5 each  live digit buses from Enhanced_Stopwatch
- go  out  1  stopwatch enable
- up  out  1  stopwatch direction
- clr  out  1  one-cycle clear pulse to stopwatch
- out0..out5  out  5 each  digit buses to LED_mux
- state  out  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE, 11 LAP
- lap_cnt  out  log2(LAP_DEPTH)+1  number of valid laps, saturating
- disp_lap  out  1  1 = outputs show a lap entry, 0 = live

Behaviour:
- Reset is asynchronous and active-low. All outputs reset to 0: state IDLE, go=0, up=0, clr=0, lap_cnt=0, disp_lap=0, out*=0. Lap buffer contents are don't-care after reset.
- Input conditioning:
  - Each raw input passes through a 2-FF synchronizer.
  - Debounced level flips on the cycle where the synchronized value has differed from it for DB_CYCLES consecutive cycles.
  - A press event is a one-cycle pulse, registered on the same cycle as the debounced 0→1 flip.
  - sw_up is debounced the same way; it has no event.
- Event priority when pulses coincide: clr > start > lap. Lower-priority events in that cycle are dropped.
- FSM (updates one cycle after the event pulse):
  - IDLE:
    - start → RUN.
    - clr → assert clr pulse, stay IDLE, lap_cnt ← 0.
    - lap ignored.
    - up tracks the debounced sw_up continuously.
  - RUN:
    - start → PAUSE.
    - lap → LAP: capture in0..in5 into buffer[wr_ptr], wr_ptr+1 (wraps), lap_cnt+1 (saturates at LAP_DEPTH), load hold timer ← HOLD_CYCLES-1.
    - clr ignored.
  - LAP:
    - Stopwatch keeps running; display frozen on the just-captured lap.
    - lap → capture again and reload timer.
    - start → PAUSE with live display.
    - Timer reaching 0 → RUN.
    - clr ignored.
  - PAUSE:
    - start → RUN with live display.
    - clr → clr pulse, IDLE, lap_cnt ← 0, wr_ptr ← 0.
    - lap with lap_cnt>0 → recall mode: the first press shows the newest entry; each further press steps one entry older, wrapping within the lap_cnt valid entries.
    - lap with lap_cnt=0 is ignored.
- go = 1 exactly in RUN and LAP.
- up is frozen while not in IDLE; sw_up changes are ignored there.
- disp_lap = 1 in LAP and in PAUSE-recall, else 0.
- out0..out5 are registered: one-cycle latency from the in* live digits, or from the selected buffer entry.
- clr is high for exactly one cycle per accepted clear.
- The lap buffer is written only on accepted lap events in RUN/LAP. Once full, it overwrites the oldest entry.
- Reset mid-operation: immediate return to reset values. No clr pulse is generated.

Test Plan:
- Run DB_CYCLES=4, HOLD_CYCLES=20.
- Press start with a 3-cycle glitch, then a clean 10-cycle hold → glitch produces no event; clean press gives go=1 one cycle after the event pulse; state=01.
- RUN, press lap with in0..in5=1,2,3,4,5,6 → state=11, disp_lap=1, out*=1..6 frozen while in* changes; after 20 cycles state=01, disp_lap=0, out* track in* with 1-cycle lag.
- Capture 5 laps (values k,k,k,k,k,k for k=1..5), then pause and press lap 5 times → lap_cnt=4; out0 sequence 5,4,3,2,5; start returns to live display.
- Press start, lap and clr on the same cycle in PAUSE → single clr pulse, state=00, lap_cnt=0, go=0.
- Toggle sw_up while in RUN → up unchanged; after clear in IDLE, up follows sw_up within DB_CYCLES+3 cycles.
- Assert rst_n=0 mid-LAP, asynchronous to clk → all outputs 0 immediately, no clr pulse; first start after release reaches RUN.
